// File: rtl/alu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_sequencer: issues the ArgonALU bus command sequence for one request and
// returns the captured Y/flags downstream.  Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int WORDSIZE = 16,
  parameter int CMD_W    = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                i_Clk,
  input  logic                i_Reset_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [WORDSIZE-1:0] i_req_a,
  input  logic [WORDSIZE-1:0] i_req_b,
  input  logic [3:0]          i_req_op,
  input  logic                i_req_flags_en,
  input  logic [7:0]          i_req_flags,
  output logic [CMD_W-1:0]    o_cmd,
  output logic [WORDSIZE-1:0] o_cmd_data,
  output logic                o_cmd_valid,
  input  logic [WORDSIZE-1:0] i_alu_data,
  input  logic                i_alu_valid,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [WORDSIZE-1:0] o_res_y,
  output logic [7:0]          o_res_flags,
  output logic                o_res_error
);

  localparam logic [CMD_W-1:0] c_COM_NONE    = CMD_W'(0);
  localparam logic [CMD_W-1:0] c_COM_LATCHA  = CMD_W'(1);
  localparam logic [CMD_W-1:0] c_COM_LATCHB  = CMD_W'(2);
  localparam logic [CMD_W-1:0] c_COM_LATCHOP = CMD_W'(3);
  localparam logic [CMD_W-1:0] c_COM_LATCHF  = CMD_W'(4);
  localparam logic [CMD_W-1:0] c_COM_COMPUTE = CMD_W'(5);
  localparam logic [CMD_W-1:0] c_COM_OUTPUTY = CMD_W'(6);
  localparam logic [CMD_W-1:0] c_COM_OUTPUTF = CMD_W'(7);
  localparam logic [7:0]       c_WAIT_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD_A  = 4'd1,
    S_LOAD_B  = 4'd2,
    S_LOAD_OP = 4'd3,
    S_LOAD_F  = 4'd4,
    S_COMPUTE = 4'd5,
    S_READ_Y  = 4'd6,
    S_READ_F  = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [WORDSIZE-1:0]   r_a;
  logic [WORDSIZE-1:0]   r_b;
  logic [3:0]            r_op;
  logic                  r_flags_en;
  logic [7:0]            r_flags;
  logic [7:0]            r_wait;
  logic [WORDSIZE-1:0]   r_res_y;
  logic [7:0]            r_res_flags;
  logic                  r_res_error;
  logic                  w_capture;
  logic                  w_timeout;
  logic                  w_in_read;

  always_comb begin
    w_next      = r_state;
    o_cmd       = c_COM_NONE;
    o_cmd_data  = '0;
    o_cmd_valid = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_in_read   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) w_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        o_cmd       = c_COM_LATCHA;
        o_cmd_data  = r_a;
        o_cmd_valid = 1'b1;
        w_next      = S_LOAD_B;
      end
      S_LOAD_B: begin
        o_cmd       = c_COM_LATCHB;
        o_cmd_data  = r_b;
        o_cmd_valid = 1'b1;
        w_next      = S_LOAD_OP;
      end
      S_LOAD_OP: begin
        o_cmd       = c_COM_LATCHOP;
        o_cmd_data  = WORDSIZE'(r_op);
        o_cmd_valid = 1'b1;
        w_next      = r_flags_en ? S_LOAD_F : S_COMPUTE;
      end
      S_LOAD_F: begin
        o_cmd       = c_COM_LATCHF;
        o_cmd_data  = WORDSIZE'(r_flags);
        o_cmd_valid = 1'b1;
        w_next      = S_COMPUTE;
      end
      S_COMPUTE: begin
        o_cmd  = c_COM_COMPUTE;
        w_next = S_READ_Y;
      end
      // Read states wait for the combinational ALU answer, bounded by TIMEOUT.
      S_READ_Y, S_READ_F: begin
        o_cmd     = (r_state == S_READ_Y) ? c_COM_OUTPUTY : c_COM_OUTPUTF;
        w_in_read = 1'b1;
        if (i_alu_valid) begin
          w_capture = 1'b1;
        end else if (r_wait == c_WAIT_LAST) begin
          w_timeout = 1'b1;
        end
        if (w_capture || w_timeout) begin
          w_next = (r_state == S_READ_Y) ? S_READ_F : S_DONE;
        end
      end
      S_DONE: begin
        if (i_res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_flags_en  <= 1'b0;
      r_flags     <= '0;
      r_wait      <= '0;
      r_res_y     <= '0;
      r_res_flags <= '0;
      r_res_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_req_valid) begin
        r_a        <= i_req_a;
        r_b        <= i_req_b;
        r_op       <= i_req_op;
        r_flags_en <= i_req_flags_en;
        r_flags    <= i_req_flags;
      end
      if (!w_in_read || w_next != r_state) begin
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + 8'd1;
      end
      if (r_state == S_READ_Y && (w_capture || w_timeout)) begin
        r_res_y     <= w_capture ? i_alu_data : '0;
        r_res_error <= w_timeout;
      end
      // Error is sticky across the Y and F reads of one operation.
      if (r_state == S_READ_F && (w_capture || w_timeout)) begin
        r_res_flags <= w_capture ? i_alu_data[7:0] : 8'h00;
        if (w_timeout) r_res_error <= 1'b1;
      end
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_res_valid = (r_state == S_DONE);
  assign o_res_y     = r_res_y;
  assign o_res_flags = r_res_flags;
  assign o_res_error = r_res_error;

endmodule
`default_nettype wire
